// File: rtl/spi_ram_ctrl_if.sv
// Bus bundle between the SPI/RAM command sequencer and its neighbours.
// Groups three channels plus one debug signal:
//   SPI side   : rx_data/rx_valid in, tx_data/tx_valid/spi_err out
//   local port : loc_req/loc_we/loc_addr/loc_wdata in,
//                loc_gnt/loc_rdata/loc_rvalid out
//   RAM port   : mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in
//   dbg_state  : current FSM state of the controller (0=IDLE, 1=ACCESS, 2=READ_RET)
// Modport slave is the controller's view; modport master is the
// environment's view (SPI slave, local requester and RAM together).
interface spi_ram_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [9:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              spi_err;
  logic              loc_req;
  logic              loc_we;
  logic [ADDR_W-1:0] loc_addr;
  logic [DATA_W-1:0] loc_wdata;
  logic              loc_gnt;
  logic [DATA_W-1:0] loc_rdata;
  logic              loc_rvalid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        dbg_state;

  modport slave (
    input  rx_data, rx_valid, loc_req, loc_we, loc_addr, loc_wdata, mem_rdata,
    output tx_data, tx_valid, spi_err, loc_gnt, loc_rdata, loc_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata, dbg_state
  );

  modport master (
    output rx_data, rx_valid, loc_req, loc_we, loc_addr, loc_wdata, mem_rdata,
    input  tx_data, tx_valid, spi_err, loc_gnt, loc_rdata, loc_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata, dbg_state
  );
endinterface

// File: rtl/spi_ram_ctrl.sv
// Command sequencer and round-robin arbiter sharing one single-port RAM
// between SPI words and a local requester.
// Ports: clk, rst_n (async, active-low), bus (spi_ram_ctrl_if.slave).
//
// Handshakes:
//   rx_valid is a 1-cycle strobe qualifying rx_data ({cmd[1:0], payload[7:0]}).
//   loc_req is held with stable fields until loc_gnt, which pulses for the
//   single cycle the local op is presented to the RAM; for reads loc_rvalid
//   pulses two cycles after loc_gnt. tx_valid is a level that rises when SPI
//   read data is captured and falls on the cycle after the next rx_valid.
//   The RAM returns mem_rdata one cycle after an enabled read.
module spi_ram_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  spi_ram_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, READ_RET = 2'd2} state_e;
  typedef enum logic {OWN_LOC = 1'b0, OWN_SPI = 1'b1} owner_e;

  localparam logic [1:0] CMD_WADDR = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_RADDR = 2'd2;
  localparam logic [1:0] CMD_READ  = 2'd3;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_owner_q, last_owner_d;
  logic              op_we_q, op_we_d;
  logic [ADDR_W-1:0] op_addr_q, op_addr_d;
  logic [DATA_W-1:0] op_wdata_q, op_wdata_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_addr_ok_q, rd_addr_ok_d;
  logic              spi_pend_q, spi_pend_d;
  logic              spi_we_q, spi_we_d;
  logic [ADDR_W-1:0] spi_addr_q, spi_addr_d;
  logic [DATA_W-1:0] spi_wdata_q, spi_wdata_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              spi_err_q, spi_err_d;
  logic [DATA_W-1:0] loc_rdata_q, loc_rdata_d;
  logic              loc_rvalid_q, loc_rvalid_d;

  logic [1:0] cmd;
  logic [7:0] payload;
  logic       slot_freeing;
  logic       pend_busy;
  logic       pick_spi;

  assign cmd     = bus.rx_data[9:8];
  assign payload = bus.rx_data[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_LOC;
      last_owner_q <= OWN_LOC;
      op_we_q      <= 1'b0;
      op_addr_q    <= '0;
      op_wdata_q   <= '0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      rd_addr_ok_q <= 1'b0;
      spi_pend_q   <= 1'b0;
      spi_we_q     <= 1'b0;
      spi_addr_q   <= '0;
      spi_wdata_q  <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      spi_err_q    <= 1'b0;
      loc_rdata_q  <= '0;
      loc_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      op_we_q      <= op_we_d;
      op_addr_q    <= op_addr_d;
      op_wdata_q   <= op_wdata_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      rd_addr_ok_q <= rd_addr_ok_d;
      spi_pend_q   <= spi_pend_d;
      spi_we_q     <= spi_we_d;
      spi_addr_q   <= spi_addr_d;
      spi_wdata_q  <= spi_wdata_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      spi_err_q    <= spi_err_d;
      loc_rdata_q  <= loc_rdata_d;
      loc_rvalid_q <= loc_rvalid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    op_we_d      = op_we_q;
    op_addr_d    = op_addr_q;
    op_wdata_d   = op_wdata_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    rd_addr_ok_d = rd_addr_ok_q;
    spi_pend_d   = spi_pend_q;
    spi_we_d     = spi_we_q;
    spi_addr_d   = spi_addr_q;
    spi_wdata_d  = spi_wdata_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    spi_err_d    = 1'b0;
    loc_rdata_d  = loc_rdata_q;
    loc_rvalid_d = 1'b0;
    pick_spi     = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.loc_gnt   = 1'b0;

    // The pending slot empties at the end of an SPI-owned ACCESS, so a word
    // arriving in that cycle may refill it without being rejected.
    slot_freeing = (state_q == ACCESS) && (owner_q == OWN_SPI);
    pend_busy    = spi_pend_q && !slot_freeing;

    // Cleared first so a same-cycle SPI read capture below takes precedence.
    if (bus.rx_valid) tx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (spi_pend_q || bus.loc_req) begin
          pick_spi     = spi_pend_q && (!bus.loc_req || (last_owner_q == OWN_LOC));
          owner_d      = pick_spi ? OWN_SPI : OWN_LOC;
          last_owner_d = owner_d;
          op_we_d      = pick_spi ? spi_we_q    : bus.loc_we;
          op_addr_d    = pick_spi ? spi_addr_q  : bus.loc_addr;
          op_wdata_d   = pick_spi ? spi_wdata_q : bus.loc_wdata;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = op_we_q;
        bus.mem_addr  = op_addr_q;
        bus.mem_wdata = op_wdata_q;
        bus.loc_gnt   = (owner_q == OWN_LOC);
        if (owner_q == OWN_SPI) spi_pend_d = 1'b0;
        state_d = op_we_q ? IDLE : READ_RET;
      end
      READ_RET: begin
        if (owner_q == OWN_SPI) begin
          tx_data_d  = 8'(bus.mem_rdata);
          tx_valid_d = 1'b1;
        end else begin
          loc_rdata_d  = bus.mem_rdata;
          loc_rvalid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // SPI decode comes after the FSM so a refill of the slot wins over the
    // ACCESS-cycle clear.
    if (bus.rx_valid) begin
      case (cmd)
        CMD_WADDR: wr_addr_d = ADDR_W'(payload);
        CMD_RADDR: begin
          rd_addr_d    = ADDR_W'(payload);
          rd_addr_ok_d = 1'b1;
        end
        CMD_WRITE: begin
          if (pend_busy) begin
            spi_err_d = 1'b1;
          end else begin
            spi_pend_d  = 1'b1;
            spi_we_d    = 1'b1;
            spi_addr_d  = wr_addr_q;
            spi_wdata_d = DATA_W'(payload);
          end
        end
        default: begin
          // Read needs a fresh cmd-10 address and a free slot; the address
          // stays armed if the read is dropped for a busy slot.
          if (!rd_addr_ok_q || pend_busy) begin
            spi_err_d = 1'b1;
          end else begin
            spi_pend_d   = 1'b1;
            spi_we_d     = 1'b0;
            spi_addr_d   = rd_addr_q;
            rd_addr_ok_d = 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.spi_err    = spi_err_q;
  assign bus.loc_rdata  = loc_rdata_q;
  assign bus.loc_rvalid = loc_rvalid_q;
  assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl: directed scenarios followed by a
// randomized serial phase checked against a transaction-level model.
module tb_spi_ram_ctrl;
  localparam int AW = 8;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_ram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  spi_ram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // ---------------- RAM behavioural model (1-cycle read latency) ----------------
  logic [DW-1:0] ram [256];
  logic [DW-1:0] ram_rdata = '0;
  assign bus.mem_rdata = ram_rdata;
  initial for (int i = 0; i < 256; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      ram_rdata <= ram[bus.mem_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [16:0] exp_q[$];
  logic [16:0] acc_q[$];
  int err_cnt, gnt_cnt, rv_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] acc(input logic we, input logic [7:0] a, input logic [7:0] d);
    return {we, a, (we ? d : 8'h00)};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_en) acc_q.push_back(acc(bus.mem_we, bus.mem_addr, bus.mem_wdata));
      if (bus.spi_err) err_cnt++;
      if (bus.loc_gnt) gnt_cnt++;
      if (bus.loc_rvalid) rv_cnt++;
    end
  end

  task automatic clear_mon();
    acc_q.delete();
    exp_q.delete();
    err_cnt = 0;
    gnt_cnt = 0;
    rv_cnt  = 0;
  endtask

  task automatic check_acc(input string tag);
    int n;
    check_eq({tag, "_acc_count"}, acc_q.size(), exp_q.size());
    n = (acc_q.size() < exp_q.size()) ? acc_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq({tag, "_acc"}, acc_q[i], exp_q[i]);
    acc_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = '0;
    bus.loc_req = 1'b0; bus.loc_we = 1'b0; bus.loc_addr = '0; bus.loc_wdata = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 after the word.
  task automatic spi_send(input logic [9:0] w);
    bus.rx_data  = w;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  // Called at a negedge; returns at the gnt negedge for writes, at the
  // loc_rvalid negedge for reads. Waits count negedges (bounded).
  task automatic loc_op(input logic we, input logic [7:0] a, input logic [7:0] d,
                        output int gnt_wait, output int rv_wait, output logic [7:0] rdata);
    bus.loc_req = 1'b1; bus.loc_we = we; bus.loc_addr = a; bus.loc_wdata = d;
    gnt_wait = 0;
    rv_wait  = 0;
    do begin
      @(negedge clk);
      gnt_wait++;
    end while (!bus.loc_gnt && gnt_wait < 20);
    bus.loc_req = 1'b0;
    if (!we) begin
      do begin
        @(negedge clk);
        rv_wait++;
      end while (!bus.loc_rvalid && rv_wait < 10);
    end
    rdata = bus.loc_rdata;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  logic [7:0] ref_mem [256];
  bit         ref_known [256];

  initial begin
    int gw, rw, k;
    logic [7:0] rd;
    logic [7:0] m_wr, m_rd, pl;
    bit m_ok, e_err, e_rd;
    logic [1:0] c;

    rst_n = 1'b0;
    do_reset();
    clear_mon();

    // Reset values
    check_eq("rst_tx_valid", bus.tx_valid, 0);
    check_eq("rst_tx_data", bus.tx_data, 0);
    check_eq("rst_spi_err", bus.spi_err, 0);
    check_eq("rst_mem_en", bus.mem_en, 0);
    check_eq("rst_loc_rvalid", bus.loc_rvalid, 0);
    check_eq("rst_loc_gnt", bus.loc_gnt, 0);

    // 1: SPI write then read round trip with exact tx latency
    spi_send(10'h055); spi_send(10'h1A7); spi_send(10'h255); spi_send(10'h300);
    check_eq("t1_txv_c1", bus.tx_valid, 0); tick(1);
    check_eq("t1_txv_c2", bus.tx_valid, 0); tick(1);
    check_eq("t1_txv_c3", bus.tx_valid, 0); tick(1);
    check_eq("t1_txv_c4", bus.tx_valid, 1);
    check_eq("t1_tx_data", bus.tx_data, 8'hA7);
    tick(3);
    check_eq("t1_txv_hold", bus.tx_valid, 1);
    check_eq("t1_err_cnt", err_cnt, 0);
    exp_q.push_back(acc(1, 8'h55, 8'hA7));
    exp_q.push_back(acc(0, 8'h55, 8'h00));
    check_acc("t1");

    // 2: read without an armed address
    do_reset(); clear_mon();
    spi_send(10'h300);
    check_eq("t2_err_c1", bus.spi_err, 1); tick(1);
    check_eq("t2_err_c2", bus.spi_err, 0); tick(4);
    check_eq("t2_txv", bus.tx_valid, 0);
    check_eq("t2_err_cnt", err_cnt, 1);
    check_acc("t2");

    // 3: local write then read
    clear_mon();
    loc_op(1, 8'h3C, 8'h12, gw, rw, rd);
    check_eq("t3_wr_gnt_wait", gw, 1);
    tick(1);
    loc_op(0, 8'h3C, 8'h00, gw, rw, rd);
    check_eq("t3_rd_gnt_wait", gw, 1);
    check_eq("t3_rvalid_wait", rw, 2);
    check_eq("t3_rdata", rd, 8'h12);
    tick(1);
    check_eq("t3_rvalid_pulse", bus.loc_rvalid, 0);
    check_eq("t3_rdata_hold", bus.loc_rdata, 8'h12);
    exp_q.push_back(acc(1, 8'h3C, 8'h12));
    exp_q.push_back(acc(0, 8'h3C, 8'h00));
    check_acc("t3");

    // 4: arbitration ties alternate
    do_reset(); clear_mon();
    spi_send(10'h010); tick(2);
    bus.rx_data = 10'h1BB; bus.rx_valid = 1'b1; @(negedge clk); bus.rx_valid = 1'b0;
    loc_op(1, 8'h20, 8'hCC, gw, rw, rd);
    check_eq("t4_tie1_gnt_wait", gw, 3);
    tick(2);
    exp_q.push_back(acc(1, 8'h10, 8'hBB));
    exp_q.push_back(acc(1, 8'h20, 8'hCC));
    check_acc("t4_tie1");
    spi_send(10'h1DD); tick(4);
    exp_q.push_back(acc(1, 8'h10, 8'hDD));
    check_acc("t4_solo");
    bus.rx_data = 10'h1EE; bus.rx_valid = 1'b1; @(negedge clk); bus.rx_valid = 1'b0;
    loc_op(1, 8'h21, 8'h77, gw, rw, rd);
    check_eq("t4_tie2_gnt_wait", gw, 1);
    tick(4);
    exp_q.push_back(acc(1, 8'h21, 8'h77));
    exp_q.push_back(acc(1, 8'h10, 8'hEE));
    check_acc("t4_tie2");

    // 5: second SPI write dropped while the first waits behind a local read
    spi_send(10'h040); tick(2); clear_mon();
    bus.loc_req = 1'b1; bus.loc_we = 1'b0; bus.loc_addr = 8'h3C;
    @(negedge clk);
    check_eq("t5_gnt", bus.loc_gnt, 1);
    bus.loc_req = 1'b0;
    bus.rx_data = 10'h111; bus.rx_valid = 1'b1;
    @(negedge clk);
    check_eq("t5_err_first", bus.spi_err, 0);
    bus.rx_data = 10'h122;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check_eq("t5_err_second", bus.spi_err, 1);
    tick(5);
    check_eq("t5_err_cnt", err_cnt, 1);
    check_eq("t5_rv_cnt", rv_cnt, 1);
    check_eq("t5_loc_rdata", bus.loc_rdata, 8'h12);
    exp_q.push_back(acc(0, 8'h3C, 8'h00));
    exp_q.push_back(acc(1, 8'h40, 8'h11));
    check_acc("t5");

    // 6: reset during READ_RET of a local read
    clear_mon();
    bus.loc_req = 1'b1; bus.loc_we = 1'b0; bus.loc_addr = 8'h3C;
    @(negedge clk);
    check_eq("t6_gnt", bus.loc_gnt, 1);
    bus.loc_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_loc_rdata", bus.loc_rdata, 0);
    check_eq("t6_rst_loc_rvalid", bus.loc_rvalid, 0);
    check_eq("t6_rst_mem", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    check_eq("t6_rst_tx", {bus.tx_valid, bus.tx_data, bus.spi_err, bus.loc_gnt}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check_eq("t6_no_rvalid", rv_cnt, 0);
    spi_send(10'h0AA); spi_send(10'h15A); spi_send(10'h2AA); spi_send(10'h300);
    k = 0;
    while (!bus.tx_valid && k < 20) begin tick(1); k++; end
    check_eq("t6_rt_tx_valid", bus.tx_valid, 1);
    check_eq("t6_rt_tx_data", bus.tx_data, 8'h5A);
    tick(1);
    loc_op(0, 8'h3C, 8'h00, gw, rw, rd);
    check_eq("t6_ram_kept", rd, 8'h12);
    tick(1);

    // 7: randomized serial traffic against a transaction-level model
    do_reset(); clear_mon();
    m_wr = 0; m_rd = 0; m_ok = 0;
    for (int i = 0; i < 256; i++) ref_known[i] = 0;
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        c  = 2'($urandom_range(0, 3));
        pl = (c == 2'd0 || c == 2'd2) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
        e_err = 0; e_rd = 0;
        case (c)
          2'd0: m_wr = pl;
          2'd1: begin
            ref_mem[m_wr] = pl; ref_known[m_wr] = 1;
            exp_q.push_back(acc(1, m_wr, pl));
          end
          2'd2: begin m_rd = pl; m_ok = 1; end
          default: begin
            if (m_ok) begin
              e_rd = 1; m_ok = 0;
              exp_q.push_back(acc(0, m_rd, 8'h00));
            end else e_err = 1;
          end
        endcase
        spi_send({c, pl});
        check_eq("rnd_spi_err", bus.spi_err, e_err);
        tick(3);
        check_eq("rnd_tx_valid", bus.tx_valid, e_rd);
        if (e_rd && ref_known[m_rd]) check_eq("rnd_tx_data", bus.tx_data, ref_mem[m_rd]);
        tick(1);
      end else begin
        logic we;
        logic [7:0] a, d;
        we = 1'($urandom_range(0, 1));
        a  = 8'($urandom_range(0, 15));
        d  = 8'($urandom_range(0, 255));
        loc_op(we, a, d, gw, rw, rd);
        check_eq("rnd_loc_gnt_wait", gw, 1);
        exp_q.push_back(acc(we, a, d));
        if (we) begin
          ref_mem[a] = d; ref_known[a] = 1;
        end else begin
          check_eq("rnd_loc_rv_wait", rw, 2);
          if (ref_known[a]) check_eq("rnd_loc_rdata", rd, ref_mem[a]);
        end
        tick(1);
      end
    end
    tick(2);
    check_acc("rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
Command sequencer and arbiter between the SPI slave and the single-port RAM. Decodes 10-bit SPI words (2-bit command + 8-bit payload) into RAM writes and reads, and returns read data to the SPI slave for shifting out on MISO. Shares the one RAM port round-robin with a local requester port.

Parameters:
ADDR_W, 8, RAM address width (depth = 2**ADDR_W)
DATA_W, 8, RAM data width; SPI payload width, fixed at 8 by the SPI word format

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  10  SPI word: [9:8]=cmd, [7:0]=payload
rx_valid  in  1  rx_data valid, 1-cycle pulse
tx_data  out  8  read data for SPI
tx_valid  out  1  tx_data valid (level)
spi_err  out  1  1-cycle pulse: SPI command rejected
loc_req  in  1  local request; hold with fields stable until loc_gnt
loc_we  in  1  1=write, 0=read
loc_addr  in  ADDR_W  local address
loc_wdata  in  DATA_W  local write data
loc_gnt  out  1  1-cycle pulse: local op issued to RAM
loc_rdata  out  DATA_W  local read data
loc_rvalid  out  1  1-cycle pulse: loc_rdata valid
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid the cycle after a read access (1-cycle latency)

Behaviour:
- Reset is asynchronous. It forces state IDLE and clears wr_addr, rd_addr, rd_addr_ok, spi_pend and the op registers. All outputs are 0 immediately. last_owner resets to LOC, so SPI wins the first tie.
- SPI decode on rx_valid=1:
  - cmd 00: wr_addr <= payload. No RAM access.
  - cmd 01: queue SPI write (addr=wr_addr, data=payload).
  - cmd 10: rd_addr <= payload; rd_addr_ok <= 1. No RAM access.
  - cmd 11: if rd_addr_ok=1, queue SPI read at rd_addr and clear rd_addr_ok. Otherwise pulse spi_err; no access.
  - Any rx_valid deasserts tx_valid in the next cycle.
- Queueing:
  - One pending SPI slot (spi_pend).
  - A queueing command (01, or 11 with a valid address) that arrives while spi_pend=1 is dropped and spi_err pulses.
  - A 00 or 10 command while pending updates the address register only. The queued op keeps its already-captured address.
- FSM states: IDLE, ACCESS, READ_RET.
  - IDLE: if spi_pend or loc_req is set, choose the owner. With only one requesting, it wins. With both, the owner is the one not equal to last_owner. Capture we/addr/wdata into op registers, set last_owner, go to ACCESS.
  - ACCESS (exactly 1 cycle): mem_en=1; mem_we/mem_addr/mem_wdata come from the op registers. If owner is LOC, loc_gnt=1 this cycle. If owner is SPI, spi_pend clears at the end of this cycle. A write goes to IDLE; a read goes to READ_RET.
  - READ_RET (1 cycle): capture mem_rdata.
    - SPI owner: tx_data <= mem_rdata and tx_valid <= 1. Both hold until the next rx_valid.
    - LOC owner: loc_rdata <= mem_rdata with a 1-cycle loc_rvalid pulse next cycle. loc_rdata holds afterwards.
    - Then go to IDLE.
- mem_* outputs are 0 outside ACCESS.
- Throughput: a write takes 2 cycles and a read 3 cycles, including IDLE.
- Latency (cycle 0 = rx_valid):
  - spi_pend visible in cycle 1, ACCESS in cycle 2, READ_RET in cycle 3, tx_valid=1 from cycle 4.
  - Local path: loc_req in cycle 0 with FSM idle gives ACCESS and loc_gnt in cycle 1, and loc_rvalid in cycle 3.
- Simultaneous events:
  - An rx_valid in the same cycle as READ_RET for SPI: the capture wins and tx_valid=1.
  - An rx_valid in the same cycle that spi_pend clears: the new op queues without error.
- Reset mid-operation: an in-flight access is abandoned, with no loc_rvalid and no tx_valid. The RAM contents are untouched.

Test Plan:
- Reset, SPI 0x055, 0x1A7, 0x255, 0x300 -> one write at mem_addr 0x55 with data 0xA7; one read at 0x55; tx_data=0xA7, tx_valid=1 from cycle 4 after the 0x300 word.
- SPI 0x300 with no prior cmd 10 -> spi_err pulses one cycle, mem_en stays 0, tx_valid stays 0.
- loc write 0x12 to addr 0x3C, then loc read 0x3C -> loc_gnt 1 cycle after each loc_req; loc_rvalid 2 cycles after the read's gnt; loc_rdata=0x12.
- SPI write queued and loc_req in the same IDLE cycle after reset -> SPI served first, LOC next. Repeat the tie -> LOC served first, confirming alternation.
- Two SPI 01 words while the first is still pending (local port holds the RAM) -> the second is dropped with spi_err=1; only one SPI write reaches the RAM.
- rst_n low during the READ_RET of a local read -> all outputs 0 at once, no loc_rvalid; after release, a SPI write-then-read round trip passes.
